// File: rtl/sdp_stream_pkg.sv
// rtl/sdp_stream_pkg.sv - shared FSM encoding and width helpers for the RAM streamer
package sdp_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-word RAM still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_skid_fifo.sv
// rtl/sync_skid_fifo.sv - register-based skid FIFO absorbing in-flight RAM reads
module sync_skid_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rptr];
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdp_ram_streamer.sv
// rtl/sdp_ram_streamer.sv - reads a full RAM frame and streams it out with backpressure
module sdp_ram_streamer
    import sdp_stream_pkg::*;
#(
    parameter int DW         = 512,
    parameter int DD         = 16384,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = RD_LAT + 2,
    localparam int AW        = addr_width(DD),
    localparam int BW        = $clog2(DD) + 1,
    localparam int CW        = credit_width(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          last_word_written,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic [DW-1:0] AXIS_TDATA,
    output logic          AXIS_TVALID,
    output logic          AXIS_TLAST,
    input  logic          AXIS_TREADY,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun,
    output logic [31:0]   frame_count
);

    state_e        r_state;
    state_e        w_next_state;
    logic [AW-1:0] r_addr;
    logic [RD_LAT-1:0] r_vld;
    logic [BW-1:0] r_beat;
    logic          r_frame_done;
    logic          r_overrun;
    logic [31:0]   r_frame_count;

    logic          w_trig;
    logic          w_issue;
    logic          w_credit_ok;
    logic          w_last_addr;
    logic          w_push;
    logic          w_pop;
    logic          w_last_beat;
    logic          w_tlast_hs;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_inflight;
    logic [CW:0]   w_credit_sum;

    assign w_trig      = start | last_word_written;
    assign w_last_addr = (r_addr == AW'(DD - 1));
    assign w_pop       = AXIS_TVALID & AXIS_TREADY;
    assign w_last_beat = (r_beat == BW'(DD - 1));
    assign w_tlast_hs  = w_pop & w_last_beat;
    assign w_push      = r_vld[RD_LAT-1] & ~w_fifo_full;

    // Reads already in the RAM pipeline reserve FIFO space before they land.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    assign w_credit_sum = (CW+1)'(w_inflight) + (CW+1)'(w_fifo_count);
    assign w_credit_ok  = (w_credit_sum < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In IDLE the address is 0, so w_last_addr there means a single-word frame.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_trig) w_next_state = w_last_addr ? ST_DRAIN : ST_READ;
            ST_READ:  if (w_issue && w_last_addr) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_tlast_hs) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        busy    = 1'b0;
        case (r_state)
            ST_IDLE:  w_issue = w_trig & w_credit_ok;
            ST_READ:  begin
                w_issue = w_credit_ok;
                busy    = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr        <= '0;
            r_vld         <= '0;
            r_beat        <= '0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_issue) begin
                r_addr <= w_last_addr ? '0 : r_addr + AW'(1);
            end else if (r_state == ST_IDLE) begin
                r_addr <= '0;
            end
            r_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (w_tlast_hs) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + BW'(1);
            end
            r_frame_done <= w_tlast_hs;
            if (w_tlast_hs) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_trig && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    sync_skid_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_wr_en   (w_push),
        .i_wr_data (dob),
        .i_rd_en   (w_pop),
        .o_rd_data (AXIS_TDATA),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign addrb       = r_addr;
    assign AXIS_TVALID = ~w_fifo_empty;
    assign AXIS_TLAST  = AXIS_TVALID & w_last_beat;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_sdp_ram_streamer.sv
// tb/tb_sdp_ram_streamer.sv - frame-level reference model bench for sdp_ram_streamer
module tb_sdp_ram_streamer;

    localparam int DW     = 32;
    localparam int DD     = 8;
    localparam int RD_LAT = 2;
    localparam int FD     = RD_LAT + 2;
    localparam int AW     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, start, lww, tready;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob, tdata;
    logic          tvalid, tlast, busy, fdone, ovr;
    logic [31:0]   fcnt;

    logic          start2, lww2, tready2;
    logic [0:0]    addrb2;
    logic [DW-1:0] dob2, tdata2;
    logic          tvalid2, tlast2, busy2, fdone2, ovr2;
    logic [31:0]   fcnt2;

    sdp_ram_streamer #(.DW(DW), .DD(DD), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .last_word_written(lww),
        .addrb(addrb), .dob(dob), .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid),
        .AXIS_TLAST(tlast), .AXIS_TREADY(tready), .busy(busy), .frame_done(fdone),
        .overrun(ovr), .frame_count(fcnt)
    );

    sdp_ram_streamer #(.DW(DW), .DD(1), .RD_LAT(1)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .last_word_written(lww2),
        .addrb(addrb2), .dob(dob2), .AXIS_TDATA(tdata2), .AXIS_TVALID(tvalid2),
        .AXIS_TLAST(tlast2), .AXIS_TREADY(tready2), .busy(busy2), .frame_done(fdone2),
        .overrun(ovr2), .frame_count(fcnt2)
    );

    // RAM models: dob follows addrb after RD_LAT clocks
    logic [DW-1:0] mem [DD];
    logic [AW-1:0] rpipe [RD_LAT];
    logic [DW-1:0] mem2;
    logic          rp2;

    always @(posedge clk) begin
        rpipe[0] <= addrb;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        rp2 <= addrb2[0];
    end
    assign dob  = mem[rpipe[RD_LAT-1]];
    assign dob2 = (rp2 == 1'b0) ? mem2 : '1;

    int tests, fails;
    int cyc, t0, fd_cyc;
    int beat_cyc [DD];
    logic [DW-1:0] exp_q [$];
    int   m_beat;
    logic m_busy, m_ovr, m_fd;
    logic [31:0] m_cnt;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_beat = 0; m_busy = 0; m_ovr = 0; m_fd = 0; m_cnt = 0;
        prev_stall = 0; prev_data = '0;
    endtask

    task automatic check_cycle();
        logic hs, nxt_busy, nxt_fd;
        if (!resetn) begin
            chk("rst_addrb", 64'(addrb), 0);
            chk("rst_tvalid", 64'(tvalid), 0);
            chk("rst_tlast", 64'(tlast), 0);
            chk("rst_tdata", 64'(tdata), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_frame_done", 64'(fdone), 0);
            chk("rst_overrun", 64'(ovr), 0);
            chk("rst_frame_count", 64'(fcnt), 0);
            model_reset();
            return;
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("overrun", 64'(ovr), 64'(m_ovr));
        chk("frame_done", 64'(fdone), 64'(m_fd));
        chk("frame_count", 64'(fcnt), 64'(m_cnt));
        chk("fifo_bound", 64'(u_dut.w_fifo_count <= FD), 1);
        if (prev_stall) begin
            chk("stall_tvalid", 64'(tvalid), 1);
            chk("stall_tdata", 64'(tdata), 64'(prev_data));
        end
        if (tvalid) begin
            if (exp_q.size() == 0) chk("spurious_tvalid", 64'(tvalid), 0);
            else begin
                chk("tdata", 64'(tdata), 64'(exp_q[0]));
                chk("tlast", 64'(tlast), 64'(m_beat == DD - 1));
            end
        end else begin
            chk("tlast_no_valid", 64'(tlast), 0);
        end
        hs = tvalid && tready && (exp_q.size() > 0);
        nxt_busy = m_busy;
        nxt_fd = 1'b0;
        if (hs) begin
            beat_cyc[m_beat] = cyc;
            void'(exp_q.pop_front());
            if (m_beat == DD - 1) begin
                m_beat = 0; nxt_busy = 1'b0; nxt_fd = 1'b1; m_cnt = m_cnt + 1;
                fd_cyc = cyc + 1;
            end else begin
                m_beat++;
            end
        end
        if (start || lww) begin
            if (m_busy) m_ovr = 1'b1;
            else begin
                for (int i = 0; i < DD; i++) exp_q.push_back(mem[i]);
                nxt_busy = 1'b1;
            end
        end
        m_busy = nxt_busy;
        m_fd = nxt_fd;
        prev_stall = tvalid & ~tready;
        prev_data = tdata;
    endtask

    task automatic step(input logic st, input logic lw, input logic rdy);
        start = st; lww = lw; tready = rdy;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0; lww = 1'b0;
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    task automatic run_to_idle(input int mode);
        logic rdy;
        for (int i = 0; i < 400; i++) begin
            if (!m_busy && !m_fd && exp_q.size() == 0) return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((i % 4) == 0) || ((i % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            step(1'b0, 1'b0, rdy);
        end
        chk("frame_timeout_busy", 64'(busy), 0);
        chk("frame_timeout_words_left", 64'(exp_q.size()), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DD; i++) mem[i] = $urandom;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; fd_cyc = 0;
        resetn = 1'b0; start = 1'b0; lww = 1'b0; tready = 1'b0;
        start2 = 1'b0; lww2 = 1'b0; tready2 = 1'b1;
        for (int i = 0; i < DD; i++) mem[i] = DW'(i);
        mem2 = $urandom;
        model_reset();
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_d2_tvalid", 64'(tvalid2), 0);
        chk("rst_d2_frame_count", 64'(fcnt2), 0);
        resetn = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        // basic frame, TREADY held high
        t0 = cyc;
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(0);
        chk("t1_first_beat_cycle", 64'(beat_cyc[0] - t0), 3);
        chk("t1_last_beat_cycle", 64'(beat_cyc[DD-1] - t0), 10);
        chk("t1_frame_done_cycle", 64'(fd_cyc - t0), 11);
        chk("t1_frame_count", 64'(fcnt), 1);

        // backpressure 1,0,0,1
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1);
        chk("t2_frame_count", 64'(fcnt), 2);

        // start and last_word_written together in IDLE
        fill_random();
        step(1'b1, 1'b1, 1'b1);
        run_to_idle(0);
        chk("t4_overrun_clear", 64'(ovr), 0);
        chk("t4_frame_count", 64'(fcnt), 3);

        // trigger while busy
        fill_random();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50 && m_beat != 3; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run_to_idle(0);
        chk("t3_overrun", 64'(ovr), 1);
        chk("t3_frame_count", 64'(fcnt), 4);
        fill_random();
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(2);
        chk("t3_second_frame_count", 64'(fcnt), 5);

        // trigger coinciding with frame_done
        fill_random();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 100 && !m_fd; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(2);
        chk("t5_frame_count", 64'(fcnt), 7);

        // reset mid-frame while stalled
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 50 && m_beat != 4; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        fill_random();
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1);
        chk("t6_frame_count", 64'(fcnt), 1);
        chk("t6_overrun", 64'(ovr), 0);

        // single-word RAM, RD_LAT=1
        start2 = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        start2 = 1'b0;
        chk("d2_c1_tvalid", 64'(tvalid2), 0);
        chk("d2_c1_busy", 64'(busy2), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("d2_c2_tvalid", 64'(tvalid2), 1);
        chk("d2_c2_tdata", 64'(tdata2), 64'(mem2));
        chk("d2_c2_tlast", 64'(tlast2), 1);
        chk("d2_c2_frame_done", 64'(fdone2), 0);
        step(1'b0, 1'b0, 1'b1);
        chk("d2_c3_frame_done", 64'(fdone2), 1);
        chk("d2_c3_tvalid", 64'(tvalid2), 0);
        chk("d2_c3_frame_count", 64'(fcnt2), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("d2_c4_frame_done", 64'(fdone2), 0);
        chk("d2_c4_busy", 64'(busy2), 0);
        chk("d2_overrun", 64'(ovr2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
